// File: rtl/spk_out_pkg.sv
// ---------------------------------------------------------------------------
// spk_out_pkg
// Shared definitions for the flit egress path (spk_out) and its testbench.
//   - flit_type_e    : 3-bit flit type codes carried in the top bits of a flit
//   - egress_state_e : egress FSM state encodings
//   - field helpers  : bit offsets/widths of the type, destination and
//                      payload fields, so every user slices flits the same way
// Flit layout (MSB..LSB): { type[FTW], destination[DW], payload[SW] }
// ---------------------------------------------------------------------------
package spk_out_pkg;

    typedef enum logic [2:0] {
        SPIKE    = 3'b000,
        DATA     = 3'b001,
        DATA_END = 3'b010,
        WRITE    = 3'b110,
        READ     = 3'b111
    } flit_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_SEND = 2'b10
    } egress_state_e;

    // Lowest bit of the type field, which occupies the top FTW bits.
    function automatic int typeLsb(input int fw, input int ftw);
        return fw - ftw;
    endfunction

    // Lowest bit of the destination field, which sits directly above the payload.
    function automatic int dstLsb(input int sw);
        return sw;
    endfunction

    // The payload always starts at bit 0.
    function automatic int dataLsb();
        return 0;
    endfunction

    // The destination field takes whatever the type and payload leave over.
    function automatic int dstWidth(input int fw, input int ftw, input int sw);
        return fw - ftw - sw;
    endfunction

endpackage

// File: rtl/data_fifo.sv
// ---------------------------------------------------------------------------
// data_fifo
// Synchronous single-clock FIFO with a registered read port.
//   clk_i    in   clock, all state on its rising edge
//   rst_i    in   synchronous active-high reset; flushes the FIFO and dout
//   wr_en_i  in   push din_i (ignored while full)
//   din_i    in   DATA_WIDTH write data
//   rd_en_i  in   pop one entry (ignored while empty)
//   dout_o   out  DATA_WIDTH read data, valid the cycle after rd_en_i
//   full_o   out  all 2^ADDR_WIDTH entries occupied
//   empty_o  out  no entries occupied
// ---------------------------------------------------------------------------
module data_fifo #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // without a separate occupancy counter.
    logic [ADDR_WIDTH:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0]   rdPtr_q, rdPtr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doWrite;
    logic                  doRead;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]) &&
                     (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]);

    assign doWrite = wr_en_i && !full_o;
    assign doRead  = rd_en_i && !empty_o;

    assign dout_o = dout_q;

    // Pointer advance and registered read data.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        dout_d  = dout_q;
        if (doWrite) begin
            wrPtr_d = wrPtr_q + (ADDR_WIDTH+1)'(1);
        end
        if (doRead) begin
            rdPtr_d = rdPtr_q + (ADDR_WIDTH+1)'(1);
            dout_d  = mem_q[rdPtr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            dout_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            mem_q[wrPtr_q[ADDR_WIDTH-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/spk_out.sv
// ---------------------------------------------------------------------------
// spk_out
// Egress side of the node flit link. Packs soma spikes/data into flits,
// forwards whole config flits, queues both in a 2^B-entry FIFO and sends them
// downstream under credit flow control (one credit per downstream buffer slot).
//   clk_spk_out          in   sole clock
//   rst                  in   synchronous active-high reset
//   soma_spk_out_vld     in   soma item present
//   soma_spk_out_data    in   SW payload
//   soma_spk_out_type    in   FTW flit type (SPIKE/DATA/DATA_END)
//   spk_out_soma_busy    out  soma item not accepted this cycle
//   config_spk_out_vld   in   config flit present
//   config_spk_out_flit  in   FW flit, forwarded bit-exact
//   spk_out_config_busy  out  config flit not accepted this cycle
//   cfg_dst              in   DW destination inserted into soma flits
//   flit_out             out  FW outgoing flit (registered)
//   flit_out_wr          out  single-cycle strobe qualifying flit_out
//   credit_in            in   single-cycle pulse: downstream popped one flit
// ---------------------------------------------------------------------------
module spk_out
    import spk_out_pkg::*;
#(
    parameter  int B      = 4,
    parameter  int FW     = 59,
    parameter  int FTW    = 3,
    parameter  int SW     = 24,
    parameter  int CREDIT = 16,
    localparam int DW     = dstWidth(FW, FTW, SW)
) (
    input  logic           clk_spk_out,
    input  logic           rst,
    input  logic           soma_spk_out_vld,
    input  logic [SW-1:0]  soma_spk_out_data,
    input  logic [FTW-1:0] soma_spk_out_type,
    output logic           spk_out_soma_busy,
    input  logic           config_spk_out_vld,
    input  logic [FW-1:0]  config_spk_out_flit,
    output logic           spk_out_config_busy,
    input  logic [DW-1:0]  cfg_dst,
    output logic [FW-1:0]  flit_out,
    output logic           flit_out_wr,
    input  logic           credit_in
);

    localparam int TYPE_LSB = typeLsb(FW, FTW);
    localparam int DST_LSB  = dstLsb(SW);
    localparam int DATA_LSB = dataLsb();
    localparam int CW       = $clog2(CREDIT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT);

    logic          fifoFull;
    logic          fifoEmpty;
    logic          fifoWrEn;
    logic [FW-1:0] fifoDin;
    logic [FW-1:0] fifoDout;
    logic          rdEn;
    logic          canPop;

    egress_state_e state_q, state_d;
    logic [FW-1:0] flitOut_q, flitOut_d;
    logic [CW-1:0] creditCnt_q, creditCnt_d;

    // Busy is taken from the FIFO state before any pop this cycle, so an entry
    // freed by a pop only becomes usable on the following cycle.
    assign spk_out_config_busy = fifoFull;
    assign spk_out_soma_busy   = fifoFull || config_spk_out_vld;

    // Ingress arbitration: config has fixed priority; at most one push per cycle.
    always_comb begin
        fifoWrEn = 1'b0;
        fifoDin  = '0;
        if (config_spk_out_vld && !fifoFull) begin
            fifoWrEn = 1'b1;
            fifoDin  = config_spk_out_flit;
        end else if (soma_spk_out_vld && !fifoFull) begin
            fifoWrEn                      = 1'b1;
            fifoDin[FW-1:TYPE_LSB]        = soma_spk_out_type;
            fifoDin[TYPE_LSB-1:DST_LSB]   = cfg_dst;
            fifoDin[DST_LSB-1:DATA_LSB]   = soma_spk_out_data;
        end
    end

    data_fifo #(
        .DATA_WIDTH(FW),
        .ADDR_WIDTH(B)
    ) u_fifo (
        .clk_i  (clk_spk_out),
        .rst_i  (rst),
        .wr_en_i(fifoWrEn),
        .din_i  (fifoDin),
        .rd_en_i(rdEn),
        .dout_o (fifoDout),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    // A pop needs both a queued flit and a free downstream slot.
    assign canPop = !fifoEmpty && (creditCnt_q != '0);

    // Egress FSM: READ waits out the registered FIFO read, SEND strobes the
    // flit. SEND can chain straight into the next READ, giving one flit per
    // two cycles at best.
    always_comb begin
        state_d   = state_q;
        rdEn      = 1'b0;
        flitOut_d = flitOut_q;
        case (state_q)
            S_IDLE: begin
                if (canPop) begin
                    rdEn    = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                flitOut_d = fifoDout;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (canPop) begin
                    rdEn    = 1'b1;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Credit is reserved at pop time and returned by credit_in; a pop and a
    // return in the same cycle cancel. A return beyond the maximum is a
    // downstream protocol error and is dropped rather than overflowing.
    always_comb begin
        creditCnt_d = creditCnt_q;
        case ({rdEn, credit_in})
            2'b10: creditCnt_d = creditCnt_q - CW'(1);
            2'b01: begin
                if (creditCnt_q != CREDIT_MAX) begin
                    creditCnt_d = creditCnt_q + CW'(1);
                end
            end
            default: creditCnt_d = creditCnt_q;
        endcase
    end

    always_ff @(posedge clk_spk_out) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flitOut_q   <= '0;
            creditCnt_q <= CREDIT_MAX;
        end else begin
            state_q     <= state_d;
            flitOut_q   <= flitOut_d;
            creditCnt_q <= creditCnt_d;
        end
    end

    assign flit_out    = flitOut_q;
    assign flit_out_wr = (state_q == S_SEND);

endmodule
